// File: rtl/fdivider.sv
// Sequential IEEE-754 single-precision divider (z = a / b), restoring mantissa division, RNE, flush-to-zero.
// Optional FDIV_FLAGS_EN adds a registered flags port {invalid, div_by_zero, overflow, underflow, inexact}.
module fdivider #(
    parameter int WIDTH = 32,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             done
`ifdef FDIV_FLAGS_EN
   ,output logic [4:0]       flags
`endif
);

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE} state_t;

    localparam logic signed [9:0] BIAS_E = 10'(BIAS);
    localparam logic [31:0]       QNAN   = 32'h7FC0_0000;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
    logic               s_q, s_d;
    logic signed [9:0]  e_q, e_d;
    logic [23:0]        mb_q, mb_d;
    logic [24:0]        r_q, r_d;
    logic [25:0]        q_q, q_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [22:0]        frac_q, frac_d;
    logic               guard_q, guard_d, sticky_q, sticky_d;
    logic               done_q, done_d, busy_q, busy_d;
`ifdef FDIV_FLAGS_EN
    logic [4:0]         flags_q, flags_d;
`endif

    // Operand classification on the latched operands; exponent 0 is zero (subnormals flushed).
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sign_w;
    logic signed [9:0] e_unp;
    assign a_nan  = (&a_q[30:23]) &  (|a_q[22:0]);
    assign a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
    assign a_zero = ~(|a_q[30:23]);
    assign b_nan  = (&b_q[30:23]) &  (|b_q[22:0]);
    assign b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
    assign b_zero = ~(|b_q[30:23]);
    assign sign_w = a_q[31] ^ b_q[31];
    assign e_unp  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + BIAS_E;

    // One restoring step: subtract when possible, then shift the partial remainder.
    logic        r_ge;
    logic [24:0] r_next;
    assign r_ge   = (r_q >= {1'b0, mb_q});
    assign r_next = r_ge ? ((r_q - {1'b0, mb_q}) << 1) : (r_q << 1);

    // Rounding on the fraction only; a carry into bit 23 means the mantissa wrapped to 1.0.
    logic              inc, ovf, unf;
    logic [23:0]       frac_r;
    logic signed [9:0] e_r;
    assign inc    = guard_q & (sticky_q | frac_q[0]);
    assign frac_r = {1'b0, frac_q} + {23'b0, inc};
    assign e_r    = e_q + {9'b0, frac_r[23]};
    assign ovf    = (e_r >= 10'sd255);
    assign unf    = (e_r <= 10'sd0);

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch behind.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        z_d      = z_q;
        s_d      = s_q;
        e_d      = e_q;
        mb_d     = mb_q;
        r_d      = r_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        frac_d   = frac_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        done_d   = 1'b0;
`ifdef FDIV_FLAGS_EN
        flags_d  = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                s_d     = sign_w;
                e_d     = e_unp;
                mb_d    = {1'b1, b_q[22:0]};
                r_d     = {2'b01, a_q[22:0]};
                q_d     = '0;
                cnt_d   = '0;
                state_d = DONE;
                done_d  = 1'b1;
                if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) begin
                    z_d = QNAN;
`ifdef FDIV_FLAGS_EN
                    flags_d = 5'b10000;
`endif
                end else if (a_inf | b_zero) begin
                    z_d = {sign_w, 8'hFF, 23'b0};
`ifdef FDIV_FLAGS_EN
                    flags_d = {1'b0, b_zero & ~a_inf, 3'b000};
`endif
                end else if (a_zero | b_inf) begin
                    z_d = {sign_w, 31'b0};
`ifdef FDIV_FLAGS_EN
                    flags_d = 5'b00000;
`endif
                end else begin
                    state_d = DIVIDE;
                    done_d  = 1'b0;
                end
            end
            DIVIDE: begin
                q_d   = {q_q[24:0], r_ge};
                r_d   = r_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) state_d = NORM;
            end
            NORM: begin
                if (q_q[25]) begin
                    frac_d   = q_q[24:2];
                    guard_d  = q_q[1];
                    sticky_d = q_q[0] | (|r_q);
                end else begin
                    frac_d   = q_q[23:1];
                    guard_d  = q_q[0];
                    sticky_d = |r_q;
                    e_d      = e_q - 10'sd1;
                end
                state_d = ROUND;
            end
            ROUND: begin
                if (ovf)      z_d = {s_q, 8'hFF, 23'b0};
                else if (unf) z_d = {s_q, 31'b0};
                else          z_d = {s_q, e_r[7:0], frac_r[22:0]};
`ifdef FDIV_FLAGS_EN
                flags_d = {2'b00, ovf, unf, guard_q | sticky_q | ovf | unf};
`endif
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, not in the sensitivity list.
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            s_q      <= 1'b0;
            e_q      <= '0;
            mb_q     <= '0;
            r_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FDIV_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z_q      <= z_d;
            s_q      <= s_d;
            e_q      <= e_d;
            mb_q     <= mb_d;
            r_q      <= r_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef FDIV_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    assign z    = z_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef FDIV_FLAGS_EN
    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fdivider.sv
// Directed self-checking bench for fdivider: results, latency, handshake and reset abort.
// Flag checks are compiled in when FDIV_FLAGS_EN is defined.
module tb_fdivider;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b, z;
    logic        busy, done;
`ifdef FDIV_FLAGS_EN
    logic [4:0]  flags;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fdivider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .z     (z),
        .busy  (busy),
        .done  (done)
`ifdef FDIV_FLAGS_EN
       ,.flags (flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT in IDLE; start is sampled on the next edge (E0).
    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] ez, input int elat, input logic [4:0] ef);
        int   lat;
        logic busy_ok;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        check({tag, " busy_after_e0"}, 32'(busy), 32'd1);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " z"}, z, ez);
        check({tag, " busy_until_done"}, 32'(busy_ok & busy), 32'd1);
`ifdef FDIV_FLAGS_EN
        check({tag, " flags"}, 32'(flags), 32'(ef));
`else
        if (ef === 5'bxxxxx) $display("note: %s flags unknown", tag);
`endif
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_after_done"}, 32'(busy), 32'd0);
        check({tag, " z_held"}, z, ez);
    endtask

    initial begin
        int          ndone;
        logic [31:0] zs;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset z", z, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_div("0.3/0.3",    32'h3E99_999A, 32'h3E99_999A, 32'h3F80_0000, 29, 5'b00000);
        run_div("6/2",        32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 29, 5'b00000);
        run_div("1/3",        32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 29, 5'b00001);
        run_div("1/0",        32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000,  1, 5'b01000);
        run_div("0/0",        32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000,  1, 5'b10000);
        run_div("-1/inf",     32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000,  1, 5'b00000);
        run_div("overflow",   32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 29, 5'b00101);
        run_div("underflow",  32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 29, 5'b00011);
        run_div("nan/1",      32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000,  1, 5'b10000);
        run_div("6/2 again",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 29, 5'b00000);

        // Reset in the middle of a divide aborts it without a done pulse.
        start = 1'b1;
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort z", z, 32'd0);
        check("abort done", 32'(done), 32'd0);
        rst   = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort no done", 32'(ndone), 32'd0);

        // Start pulses while busy and during DONE must be ignored.
        start = 1'b1;
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'h3F80_0000;
        b     = 32'h0000_0000;
        ndone = 0;
        zs    = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                zs = z;
                if (ndone == 1) begin
                    start = 1'b1;
                    a     = 32'h3F80_0000;
                    b     = 32'h0000_0000;
                end
            end
        end
        check("busy start one done", 32'(ndone), 32'd1);
        check("busy start z", zs, 32'h4040_0000);
        check("busy start idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fdivider.md
Name: fdivider

Overview:
- Sequential IEEE-754 single-precision divider computing z = a / b. It is the inverse-operation companion to fmultiplier and shares its 32-bit operand/result format and clk/rst naming.
- Iterative restoring mantissa division under a start/busy/done handshake: one quotient bit per cycle, round-to-nearest-even, flush-to-zero for subnormals.
- Sits beside fmultiplier in the FP datapath.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (1 sign, 8 exponent, 23 fraction).
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- a  input  32  dividend.
- b  input  32  divisor.
- z  output  32  quotient; registered; held until the next done.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; z is valid when done is high.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; z=0, busy=0, done=0, internal registers cleared. A reset mid-operation aborts the operation and produces no done pulse.
- Start handling:
  - start sampled in IDLE: a and b are latched; a/b may change afterwards.
  - start is ignored in all other states, including DONE.
- FSM: IDLE -> UNPACK -> DIVIDE -> NORM -> ROUND -> DONE -> IDLE.
  - UNPACK -> DONE directly for special cases.
- Latency, counting the start-sampling edge as E0:
  - Normal operands: UNPACK after E0, DIVIDE after E1 (26 cycles), NORM after E27, ROUND after E28, done=1 after E29.
  - Special cases: done=1 after E1.
  - Back-to-back: the earliest next start is sampled in IDLE, one cycle after done.
- UNPACK:
  - Sign s = a[31]^b[31].
  - Exponent field 0 means zero; subnormal inputs are treated as signed zero.
  - Mantissas ma = {1, a[22:0]}, mb = {1, b[22:0]}.
  - Biased exponent e = ea - eb + 127, held as a 10-bit signed value.
- Special-case priority (first match wins):
  1. Either operand NaN -> 0x7FC00000.
  2. inf/inf or 0/0 -> 0x7FC00000.
  3. inf/finite or finite-nonzero/0 -> {s, 0xFF, 0}.
  4. 0/finite or finite/inf -> {s, 31'b0}.
- DIVIDE (restoring): r = ma (25 bits). Repeat 26 times:
  - if r >= mb: q = {q,1} and r = r - mb; else q = {q,0}.
  - then r = r << 1.
  - A 5-bit iteration counter runs 0..25.
- NORM:
  - If q[25]=1: mant = q[25:2], guard = q[1], sticky = q[0] | (r != 0).
  - Else: mant = q[24:1], guard = q[0], sticky = (r != 0), e = e - 1.
- ROUND (RNE):
  - Increment when guard & (sticky | mant[0]).
  - If the mantissa carries out: mant = 0x800000, e = e + 1.
- Range handling:
  - e >= 255 -> {s, 0xFF, 0} (overflow).
  - e <= 0 -> {s, 31'b0} (underflow, FTZ).
  - Otherwise z = {s, e[7:0], mant[22:0]}.
- DONE: z is updated on entry; done=1 for exactly one cycle; next state IDLE.

Optional Feature:
- Macro FDIV_FLAGS_EN.
- Defined: adds output port flags [4:0] = {invalid, div_by_zero, overflow, underflow, inexact}.
  - Registered and updated together with z; cleared by reset.
  - invalid: NaN input, 0/0, or inf/inf.
  - div_by_zero: finite-nonzero/0.
  - inexact: guard | sticky, or any overflow/underflow.
- Undefined: no flags port or logic; z, busy and done behave identically.

Test Plan:
- 0x3E99999A / 0x3E99999A -> z=0x3F800000; done high exactly after E29; busy high from E0 through DONE.
- 0x40C00000 / 0x40000000 -> 0x40400000. 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (RNE rounds up; flags inexact=1).
- 0x3F800000 / 0x00000000 -> 0x7F800000 with done after E1 (div_by_zero=1). 0x00000000 / 0x00000000 -> 0x7FC00000 (invalid=1). 0xBF800000 / 0x7F800000 -> 0x80000000.
- 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow). 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
- Reset and handshake:
  - Drive rst=0 at cycle 10 of a divide -> busy=0 and z=0 next cycle; no done pulse.
  - Pulse start while busy -> ignored; only one done is produced and a/b are not re-latched.
